// File: rtl/pixel_dispatcher_if.sv
// pixel_dispatcher_if: frame request, per-core job handshake and status
// signals shared between the pixel dispatcher and its environment.
// master = dispatcher side, slave = frame controller / core array side.
interface pixel_dispatcher_if #(
    parameter int NUM_CORES = 2,
    parameter int DIM_W     = 13
);
    logic                 start;
    logic [DIM_W-1:0]     image_width;
    logic [DIM_W-1:0]     image_height;
    logic [2:0]           no_of_extra_cores;
    logic [NUM_CORES-1:0] core_ready;
    logic [NUM_CORES-1:0] core_valid;
    logic [DIM_W-1:0]     x_out;
    logic [DIM_W-1:0]     y_out;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  start, image_width, image_height, no_of_extra_cores, core_ready,
        output core_valid, x_out, y_out, busy, frame_done
    );

    modport slave (
        output start, image_width, image_height, no_of_extra_cores, core_ready,
        input  core_valid, x_out, y_out, busy, frame_done
    );
endinterface

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: hands out pixel jobs (x, y) in raster order, round-robin
// over the active ray-tracing cores, one job per cycle at most.
// Optional feature: define DISPATCH_CONTINUOUS_EN to restart a new frame
// straight from DONE instead of returning to IDLE.
module pixel_dispatcher #(
    parameter int NUM_CORES = 2,
    parameter int DIM_W     = 13
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pixel_dispatcher_if.master   bus
);

    typedef enum logic [1:0] {IDLE, DISPATCH, DONE} state_t;

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t               state, state_d;
    logic [DIM_W-1:0]     x_q, x_d, y_q, y_d;
    logic [2:0]           tgt_q, tgt_d;
    logic [DIM_W-1:0]     width_q, height_q;
    logic [3:0]           ncores_q;
    logic [NUM_CORES-1:0] core_valid_q, core_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 latch_en, zero_frame, xfer, last_job, dims_ok;

    // Active core count: requested count, saturated to the cores that exist.
    function automatic logic [3:0] clamp_cores(input logic [2:0] extra);
        logic [3:0] want;
        want = {1'b0, extra} + 4'd1;
        if (want > 4'(NUM_CORES)) begin
            return 4'(NUM_CORES);
        end
        return want;
    endfunction

    assign dims_ok  = (bus.image_width != '0) && (bus.image_height != '0);
    // core_valid is one-hot on the target, so ready on other cores masks out.
    assign xfer     = (state == DISPATCH) && (|(core_valid_q & bus.core_ready));
    assign last_job = (x_q == width_q - ONE) && (y_q == height_q - ONE);

    // Next state plus raster/round-robin position update.
    always_comb begin
        state_d    = state;
        x_d        = x_q;
        y_d        = y_q;
        tgt_d      = tgt_q;
        latch_en   = 1'b0;
        zero_frame = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (dims_ok) begin
                        state_d  = DISPATCH;
                        latch_en = 1'b1;
                        x_d      = '0;
                        y_d      = '0;
                        tgt_d    = '0;
                    end else begin
                        zero_frame = 1'b1;
                    end
                end
            end
            DISPATCH: begin
                if (xfer) begin
                    if (last_job) begin
                        state_d = DONE;
                    end else begin
                        if (x_q == width_q - ONE) begin
                            x_d = '0;
                            y_d = y_q + ONE;
                        end else begin
                            x_d = x_q + ONE;
                        end
                        if ({1'b0, tgt_q} == ncores_q - 4'd1) begin
                            tgt_d = '0;
                        end else begin
                            tgt_d = tgt_q + 3'd1;
                        end
                    end
                end
            end
            DONE: begin
`ifdef DISPATCH_CONTINUOUS_EN
                // A zero-sized frame cannot be looped; fall back to IDLE.
                if (dims_ok) begin
                    state_d  = DISPATCH;
                    latch_en = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                    tgt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        core_valid_d = '0;
        if (state_d == DISPATCH) begin
            core_valid_d = NUM_CORES'(1) << tgt_d;
        end
        busy_d       = (state_d != IDLE);
        frame_done_d = zero_frame || ((state == DISPATCH) && (state_d == DONE));
    end

    // State, position and output registers; reset abandons any frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            tgt_q        <= '0;
            core_valid_q <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tgt_q        <= tgt_d;
            core_valid_q <= core_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame geometry captured at frame start; later input changes are ignored.
    always_ff @(posedge aclk) begin
        if (latch_en) begin
            width_q  <= bus.image_width;
            height_q <= bus.image_height;
            ncores_q <= clamp_cores(bus.no_of_extra_cores);
        end
    end

    assign bus.core_valid = core_valid_q;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher: directed scenarios for pixel_dispatcher with
// hand-computed expected job sequences. Honours DISPATCH_CONTINUOUS_EN.
module tb_pixel_dispatcher;
    localparam int NC = 2;
    localparam int DW = 13;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    pixel_dispatcher_if #(.NUM_CORES(NC), .DIM_W(DW)) bus ();

    pixel_dispatcher #(.NUM_CORES(NC), .DIM_W(DW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    task automatic test_reset();
        bus.start = 1'b0;
        bus.image_width = '0;
        bus.image_height = '0;
        bus.no_of_extra_cores = 3'd0;
        bus.core_ready = 2'b00;
        aresetn = 1'b0;
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.x_out !== 13'd0 || bus.y_out !== 13'd0 ||
            bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cv=%b x=%0d y=%0d busy=%b fd=%b, want all 0",
                     bus.core_valid, bus.x_out, bus.y_out, bus.busy, bus.frame_done);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: cv=%b busy=%b fd=%b, want 00 0 0",
                     bus.core_valid, bus.busy, bus.frame_done);
        end
    endtask

`ifndef DISPATCH_CONTINUOUS_EN
    // 4x2 frame, two cores: 8 jobs back to back, cores alternate.
    task automatic test_raster();
        logic [1:0] exp_cv;
        bus.image_width = 13'd4;
        bus.image_height = 13'd2;
        bus.no_of_extra_cores = 3'd1;
        bus.core_ready = 2'b11;
        bus.start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            bus.start = 1'b0;
            exp_cv = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.core_valid !== exp_cv || bus.x_out !== DW'(k % 4) || bus.y_out !== DW'(k / 4) ||
                bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL raster_job%0d: cv=%b x=%0d y=%0d busy=%b fd=%b, want cv=%b x=%0d y=%0d busy=1 fd=0",
                         k, bus.core_valid, bus.x_out, bus.y_out, bus.busy, bus.frame_done,
                         exp_cv, k % 4, k / 4);
            end
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.busy !== 1'b1 || bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL raster_done: cv=%b busy=%b fd=%b, want 00 1 1",
                     bus.core_valid, bus.busy, bus.frame_done);
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL raster_idle: cv=%b busy=%b fd=%b, want 00 0 0",
                     bus.core_valid, bus.busy, bus.frame_done);
        end
    endtask

    // Core 1 withholds ready at job (1,0) for 5 cycles; start held high meanwhile.
    task automatic test_stall();
        bus.image_width = 13'd4;
        bus.image_height = 13'd1;
        bus.no_of_extra_cores = 3'd1;
        bus.core_ready = 2'b11;
        bus.start = 1'b1;
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b01 || bus.x_out !== 13'd0 || bus.y_out !== 13'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_job0: cv=%b x=%0d y=%0d busy=%b, want 01 0 0 1",
                     bus.core_valid, bus.x_out, bus.y_out, bus.busy);
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b10 || bus.x_out !== 13'd1 || bus.y_out !== 13'd0) begin
            errors++;
            $display("FAIL stall_job1: cv=%b x=%0d y=%0d, want 10 1 0",
                     bus.core_valid, bus.x_out, bus.y_out);
        end
        bus.core_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (bus.core_valid !== 2'b10 || bus.x_out !== 13'd1 || bus.y_out !== 13'd0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: cv=%b x=%0d y=%0d busy=%b, want 10 1 0 1",
                         i, bus.core_valid, bus.x_out, bus.y_out, bus.busy);
            end
            if (i == 4) bus.core_ready = 2'b11;
        end
        @(negedge aclk);
        bus.start = 1'b0;
        checks++;
        if (bus.core_valid !== 2'b01 || bus.x_out !== 13'd2 || bus.y_out !== 13'd0) begin
            errors++;
            $display("FAIL stall_resume2: cv=%b x=%0d y=%0d, want 01 2 0",
                     bus.core_valid, bus.x_out, bus.y_out);
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b10 || bus.x_out !== 13'd3 || bus.y_out !== 13'd0) begin
            errors++;
            $display("FAIL stall_resume3: cv=%b x=%0d y=%0d, want 10 3 0",
                     bus.core_valid, bus.x_out, bus.y_out);
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.busy !== 1'b1 || bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: cv=%b busy=%b fd=%b, want 00 1 1",
                     bus.core_valid, bus.busy, bus.frame_done);
        end
        @(negedge aclk);
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.core_valid !== 2'b00) begin
            errors++;
            $display("FAIL stall_idle: cv=%b busy=%b fd=%b, want 00 0 0",
                     bus.core_valid, bus.busy, bus.frame_done);
        end
    endtask

    // extra=7 clamps to 2 cores; inputs changed mid-frame must not matter.
    task automatic test_clamp();
        logic [1:0] exp_cv;
        bus.image_width = 13'd3;
        bus.image_height = 13'd2;
        bus.no_of_extra_cores = 3'd7;
        bus.core_ready = 2'b11;
        bus.start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge aclk);
            bus.start = 1'b0;
            if (k == 2) begin
                bus.image_width = 13'd5;
                bus.image_height = 13'd7;
                bus.no_of_extra_cores = 3'd0;
            end
            exp_cv = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.core_valid !== exp_cv || bus.x_out !== DW'(k % 3) || bus.y_out !== DW'(k / 3)) begin
                errors++;
                $display("FAIL clamp_job%0d: cv=%b x=%0d y=%0d, want cv=%b x=%0d y=%0d",
                         k, bus.core_valid, bus.x_out, bus.y_out, exp_cv, k % 3, k / 3);
            end
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL clamp_done: cv=%b fd=%b, want 00 1", bus.core_valid, bus.frame_done);
        end
        @(negedge aclk);
    endtask

    // One active core: every job goes to core 0.
    task automatic test_single_core();
        bus.image_width = 13'd3;
        bus.image_height = 13'd1;
        bus.no_of_extra_cores = 3'd0;
        bus.core_ready = 2'b11;
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            bus.start = 1'b0;
            checks++;
            if (bus.core_valid !== 2'b01 || bus.x_out !== DW'(k) || bus.y_out !== 13'd0) begin
                errors++;
                $display("FAIL single_job%0d: cv=%b x=%0d y=%0d, want cv=01 x=%0d y=0",
                         k, bus.core_valid, bus.x_out, bus.y_out, k);
            end
        end
        @(negedge aclk);
        checks++;
        if (bus.core_valid !== 2'b00 || bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL single_done: cv=%b fd=%b, want 00 1", bus.core_valid, bus.frame_done);
        end
        @(negedge aclk);
    endtask

    // Reset asserted mid-frame at job (2,1): outputs clear without a clock edge.
    task automatic test_reset_mid_frame();
        bus.image_width = 13'd4;
        bus.image_height = 13'd2;
        bus.no_of_extra_cores = 3'd1;
        bus.core_ready = 2'b11;
        bus.start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge aclk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.core_valid !== 2'b01 || bus.x_out !== 13'd2 || bus.y_out !== 13'd1) begin
            errors++;
            $display("FAIL rstmid_at_job: cv=%b x=%0d y=%0d, want 01 2 1",
                     bus.core_valid, bus.x_out, bus.y_out);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (bus.core_valid !== 2'b00 || bus.x_out !== 13'd0 || bus.y_out !== 13'd0 ||
            bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: cv=%b x=%0d y=%0d busy=%b fd=%b, want all 0",
                     bus.core_valid, bus.x_out, bus.y_out, bus.busy, bus.frame_done);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++;
            if (bus.core_valid !== 2'b00 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d: cv=%b busy=%b fd=%b, want 00 0 0",
                         i, bus.core_valid, bus.busy, bus.frame_done);
            end
        end
    endtask
`endif

    // Zero width or zero height: no jobs, a lone frame_done pulse, never busy.
    task automatic test_zero_dim();
        for (int c = 0; c < 2; c++) begin
            bus.image_width  = (c == 0) ? 13'd0 : 13'd7;
            bus.image_height = (c == 0) ? 13'd5 : 13'd0;
            bus.no_of_extra_cores = 3'd1;
            bus.core_ready = 2'b11;
            bus.start = 1'b1;
            @(negedge aclk);
            bus.start = 1'b0;
            checks++;
            if (bus.core_valid !== 2'b00 || bus.busy !== 1'b0 || bus.frame_done !== 1'b1) begin
                errors++;
                $display("FAIL zero_dim%0d_pulse: cv=%b busy=%b fd=%b, want 00 0 1",
                         c, bus.core_valid, bus.busy, bus.frame_done);
            end
            @(negedge aclk);
            checks++;
            if (bus.core_valid !== 2'b00 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL zero_dim%0d_after: cv=%b busy=%b fd=%b, want 00 0 0",
                         c, bus.core_valid, bus.busy, bus.frame_done);
            end
        end
    endtask

`ifdef DISPATCH_CONTINUOUS_EN
    // 2x1 frames repeat: (0,0)c0, (1,0)c1, done pulse, then restart; busy stays 1.
    task automatic test_continuous();
        bus.image_width = 13'd2;
        bus.image_height = 13'd1;
        bus.no_of_extra_cores = 3'd1;
        bus.core_ready = 2'b11;
        bus.start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            @(negedge aclk);
            bus.start = 1'b0;
            checks++;
            if (bus.core_valid !== 2'b01 || bus.x_out !== 13'd0 || bus.y_out !== 13'd0 ||
                bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL cont_f%0d_job0: cv=%b x=%0d y=%0d busy=%b fd=%b, want 01 0 0 1 0",
                         f, bus.core_valid, bus.x_out, bus.y_out, bus.busy, bus.frame_done);
            end
            @(negedge aclk);
            checks++;
            if (bus.core_valid !== 2'b10 || bus.x_out !== 13'd1 || bus.y_out !== 13'd0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL cont_f%0d_job1: cv=%b x=%0d y=%0d busy=%b, want 10 1 0 1",
                         f, bus.core_valid, bus.x_out, bus.y_out, bus.busy);
            end
            @(negedge aclk);
            checks++;
            if (bus.core_valid !== 2'b00 || bus.busy !== 1'b1 || bus.frame_done !== 1'b1) begin
                errors++;
                $display("FAIL cont_f%0d_done: cv=%b busy=%b fd=%b, want 00 1 1",
                         f, bus.core_valid, bus.busy, bus.frame_done);
            end
        end
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
`ifdef DISPATCH_CONTINUOUS_EN
        test_zero_dim();
        test_continuous();
`else
        test_raster();
        test_stall();
        test_clamp();
        test_single_core();
        test_zero_dim();
        test_reset_mid_frame();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
